// File: rtl/fetch_if.sv
// fetch_if -- instruction fetch bus between the fetch unit and its environment.
//   instr_in     ROM word at address pc (combinational read)
//   stall        hold the PC this cycle
//   branch_en    taken branch this cycle
//   branch_rel   1: relative (branch_addr[7:0] signed), 0: absolute (branch_addr)
//   branch_addr  branch target / offset
//   pc           current fetch address
//   instr_valid  instr_in is executable this cycle
//   halt         fetch has stopped on HALT_OP
//   cycle_count  RUN cycles executed (0 unless FETCH_CYCLE_COUNT_EN)
// master = environment side, slave = fetch_unit side.
interface fetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic [INSTR_W-1:0] instr_in;
    logic               stall;
    logic               branch_en;
    logic               branch_rel;
    logic [PC_W-1:0]    branch_addr;
    logic [PC_W-1:0]    pc;
    logic               instr_valid;
    logic               halt;
    logic [15:0]        cycle_count;

    modport master (
        output instr_in, stall, branch_en, branch_rel, branch_addr,
        input  pc, instr_valid, halt, cycle_count
    );

    modport slave (
        input  instr_in, stall, branch_en, branch_rel, branch_addr,
        output pc, instr_valid, halt, cycle_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- PC sequencer with stall, absolute/relative branch and halt.
//   CLK    single clock, rising edge
//   start  synchronous active-high reset; the first edge with start low
//          launches fetch (one-cycle IDLE bubble, pc=0, instr_valid=0)
//   bus    fetch_if.slave: instruction/branch/stall in, pc/valid/halt/count out
// Optional feature: define FETCH_CYCLE_COUNT_EN to build the saturating RUN
// cycle counter; otherwise cycle_count is tied to zero.
// PC_W must be at least 8 (relative offset is branch_addr[7:0]).
module fetch_unit #(
    parameter int                 PC_W    = 10,
    parameter int                 INSTR_W = 9,
    parameter logic [INSTR_W-1:0] HALT_OP = {INSTR_W{1'b1}}
) (
    input  logic   CLK,
    input  logic   start,
    fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            halt_q, halt_nxt;
    logic            valid;
    logic            is_halt;
    logic [PC_W-1:0] rel_off;

    assign is_halt = (bus.instr_in == HALT_OP);
    assign rel_off = {{(PC_W-8){bus.branch_addr[7]}}, bus.branch_addr[7:0]};

    // Stall outranks halt so a HALT_OP under stall waits; halt outranks branch.
    // PC adds wrap naturally at PC_W bits.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        halt_nxt  = halt_q;
        valid     = 1'b0;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                valid = ~bus.stall & ~is_halt;
                if (bus.stall) begin
                    pc_nxt = pc_q;
                end else if (is_halt) begin
                    state_nxt = HALTED;
                    halt_nxt  = 1'b1;
                end else if (bus.branch_en) begin
                    pc_nxt = bus.branch_rel ? pc_q + rel_off : bus.branch_addr;
                end else begin
                    pc_nxt = pc_q + PC_W'(1);
                end
            end
            HALTED: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state  <= IDLE;
            pc_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            halt_q <= halt_nxt;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.halt        = halt_q;
    assign bus.instr_valid = valid;

`ifdef FETCH_CYCLE_COUNT_EN
    // Counts every RUN cycle, stalled ones too; sticks at all-ones.
    logic [15:0] cnt_q;
    always_ff @(posedge CLK) begin
        if (start)
            cnt_q <= '0;
        else if (state == RUN && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end
    assign bus.cycle_count = cnt_q;
`else
    assign bus.cycle_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 1 << PC_W;
    localparam logic [INSTR_W-1:0] HALT = {INSTR_W{1'b1}};
`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic start = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [INSTR_W-1:0] rom [0:DEPTH-1];

    fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_OP(HALT)) dut (
        .CLK   (clk),
        .start (start),
        .bus   (bus)
    );

    assign bus.instr_in = rom[bus.pc];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = waiting for launch, 1 = fetching, 2 = stopped
    int m_phase = 0;
    int m_pc    = 0;
    int m_halt  = 0;
    int m_cnt   = 0;
    bit seen_reset = 1'b0;

    always @(posedge clk) begin
        int off;
        off = int'(bus.branch_addr[7:0]);
        if (off >= 128) off = off - 256;
        if (start) begin
            seen_reset <= 1'b1;
            m_phase <= 0; m_pc <= 0; m_halt <= 0; m_cnt <= 0;
        end else if (m_phase == 0) begin
            m_phase <= 1;
        end else if (m_phase == 1) begin
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (bus.stall) begin
                // hold
            end else if (rom[m_pc] == HALT) begin
                m_phase <= 2; m_halt <= 1;
            end else if (bus.branch_en && !bus.branch_rel) begin
                m_pc <= int'(bus.branch_addr);
            end else if (bus.branch_en) begin
                m_pc <= (m_pc + off + DEPTH) % DEPTH;
            end else begin
                m_pc <= (m_pc + 1) % DEPTH;
            end
        end
    end

    // one compare process, every cycle once reset has been seen
    always @(negedge clk) begin
        if (seen_reset) begin
            chk("pc", 32'(bus.pc), 32'(m_pc));
            chk("halt", 32'(bus.halt), 32'(m_halt));
            chk("instr_valid", 32'(bus.instr_valid),
                32'(m_phase == 1 && !bus.stall && rom[m_pc] != HALT));
            chk("cycle_count", 32'(bus.cycle_count), CNT_EN ? 32'(m_cnt) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nonzero words; roughly halt_pct % of them HALT
    task automatic fill_rom(input int halt_pct);
        logic [INSTR_W-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'($urandom_range(99)) < halt_pct) begin
                rom[i] = HALT;
            end else begin
                w = INSTR_W'($urandom);
                while (w == '0 || w == HALT) w = INSTR_W'($urandom);
                rom[i] = w;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_rel = 1'b0; bus.branch_addr = '0;
    endtask

    // reset for two edges, then release; returns in the IDLE launch bubble
    task automatic do_reset();
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        fill_rom(0);

        // straight-line fetch, HALT at 5
        rom[5] = HALT;
        do_reset();
        chk("reset_pc", 32'(bus.pc), 32'd0);
        chk("reset_halt", 32'(bus.halt), 32'd0);
        chk("reset_cnt", 32'(bus.cycle_count), 32'd0);
        chk("bubble_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("line_pc", 32'(bus.pc), 32'(i));
            chk("line_halt", 32'(bus.halt), 32'd0);
        end
        tick();
        chk("line_halt_rise", 32'(bus.halt), 32'd1);
        chk("line_halt_pc", 32'(bus.pc), 32'd5);
        chk("line_count", 32'(bus.cycle_count), CNT_EN ? 32'd6 : 32'd0);
        rom[5] = 9'h05;

        // absolute branch at pc=2
        do_reset();
        tick(); tick(); tick();
        chk("abs_at", 32'(bus.pc), 32'd2);
        bus.branch_en = 1'b1; bus.branch_rel = 1'b0; bus.branch_addr = 10'h3F0;
        tick();
        chk("abs_target", 32'(bus.pc), 32'h3F0);
        idle_inputs();

        // relative branch -4 from pc=1, then wrap past the top
        do_reset();
        tick(); tick();
        chk("rel_at", 32'(bus.pc), 32'd1);
        bus.branch_en = 1'b1; bus.branch_rel = 1'b1; bus.branch_addr = 10'h0FC;
        tick();
        chk("rel_target", 32'(bus.pc), 32'h3FD);
        idle_inputs();
        tick(); tick();
        chk("wrap_top", 32'(bus.pc), 32'h3FF);
        tick();
        chk("wrap_zero", 32'(bus.pc), 32'd0);

        // stall over halt at pc=3
        rom[3] = HALT;
        do_reset();
        tick(); tick(); tick(); tick();
        chk("stall_at", 32'(bus.pc), 32'd3);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_pc", 32'(bus.pc), 32'd3);
            chk("stall_halt", 32'(bus.halt), 32'd0);
        end
        bus.stall = 1'b0;
        tick();
        chk("stall_halt_rise", 32'(bus.halt), 32'd1);
        chk("stall_halt_pc", 32'(bus.pc), 32'd3);
        // halted ignores stall and branch
        bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_addr = 10'h100;
        tick();
        bus.stall = 1'b0;
        tick();
        chk("halted_pc", 32'(bus.pc), 32'd3);
        chk("halted_valid", 32'(bus.instr_valid), 32'd0);
        idle_inputs();
        rom[3] = 9'h03;

        // reset mid-run at pc=7 with a branch pending
        do_reset();
        repeat (8) tick();
        chk("mid_at", 32'(bus.pc), 32'd7);
        start = 1'b1; bus.branch_en = 1'b1; bus.branch_addr = 10'h200; bus.stall = 1'b1;
        tick();
        chk("mid_pc", 32'(bus.pc), 32'd0);
        chk("mid_halt", 32'(bus.halt), 32'd0);
        chk("mid_cnt", 32'(bus.cycle_count), 32'd0);
        start = 1'b0; idle_inputs();
        chk("mid_bubble", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("mid_resume0", 32'(bus.pc), 32'd0);
        chk("mid_resume_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        chk("mid_resume1", 32'(bus.pc), 32'd1);

        // randomized segments, checked every cycle by the model
        for (int s = 0; s < 20; s++) begin
            start = 1'b1;
            fill_rom(int'($urandom_range(3)));
            tick(); tick();
            start = 1'b0;
            for (int c = 0; c < 150; c++) begin
                tick();
                bus.stall       = ($urandom_range(4) == 0);
                bus.branch_en   = ($urandom_range(5) == 0);
                bus.branch_rel  = 1'($urandom);
                bus.branch_addr = PC_W'($urandom);
                start           = ($urandom_range(99) == 0);
            end
            idle_inputs();
        end
        start = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
